// File: rtl/hps_noc_mailbox_if.sv
// PIO register bank and NoC local-port signals of one mailbox channel.
// slave = the mailbox block, master = the HPS/router side driving it.
interface hps_noc_mailbox_if #(
  parameter int NUM_WORDS = 8,
  parameter int DATA_W    = 32,
  parameter int FLIT_W    = 64
);
  logic [NUM_WORDS*DATA_W-1:0] tx_words_i;
  logic [31:0]                 ctrl_i;
  logic [31:0]                 status_o;
  logic [NUM_WORDS*DATA_W-1:0] rx_words_o;

  // Flit channels: a flit transfers on a rising clk edge where valid && ready
  // are both high; once valid is raised, valid and data hold until that edge.
  logic [FLIT_W-1:0]           noc_tx_data_o;
  logic                        noc_tx_valid_o;
  logic                        noc_tx_ready_i;
  logic [FLIT_W-1:0]           noc_rx_data_i;
  logic                        noc_rx_valid_i;
  logic                        noc_rx_ready_o;

  // Serialiser state for observation: 0 = idle, 1 = sending.
  logic                        tx_state_dbg;

  modport slave (
    input  tx_words_i, ctrl_i, noc_tx_ready_i, noc_rx_data_i, noc_rx_valid_i,
    output status_o, rx_words_o, noc_tx_data_o, noc_tx_valid_o, noc_rx_ready_o,
    output tx_state_dbg
  );

  modport master (
    output tx_words_i, ctrl_i, noc_tx_ready_i, noc_rx_data_i, noc_rx_valid_i,
    input  status_o, rx_words_o, noc_tx_data_o, noc_tx_valid_o, noc_rx_ready_o,
    input  tx_state_dbg
  );
endinterface

// File: rtl/hps_noc_mailbox.sv
// HPS PIO <-> NoC local-port mailbox: TX message FIFO + flit serialiser, RX flit assembler.
// Optional HPS_NOC_MBX_STATS_EN: status_o[31:16] counts completed TX packets (saturating).
module hps_noc_mailbox #(
  parameter int NUM_WORDS  = 8,
  parameter int DATA_W     = 32,
  parameter int FLIT_W     = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  hps_noc_mailbox_if.slave  bus
);
  localparam int MSG_W = NUM_WORDS * DATA_W;
  localparam int FLITS = MSG_W / FLIT_W;
  localparam int FC_W  = (FLITS > 1) ? $clog2(FLITS) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic { TX_IDLE = 1'b0, TX_SEND = 1'b1 } tx_state_t;

  logic soft_clr;
  logic unused_ctrl;
  assign soft_clr    = bus.ctrl_i[2];
  assign unused_ctrl = ^bus.ctrl_i[31:3];

  // ---------------- TX message FIFO ----------------
  logic [MSG_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_cnt;
  logic             tx_seen;

  tx_state_t        tx_state;
  logic [MSG_W-1:0] tx_shreg;
  logic [FC_W-1:0]  tx_fcnt;
  logic             tx_valid;

  logic fifo_full, fifo_empty, tx_hs, tx_last, fifo_pop, fifo_push;

  always_comb begin
    fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    fifo_empty = (fifo_cnt == '0);
    tx_hs      = tx_valid && bus.noc_tx_ready_i;
    tx_last    = tx_hs && (tx_fcnt == FC_W'(FLITS - 1));
    // Clear flushes queued entries, so nothing is popped or pushed while it is held.
    fifo_pop   = !soft_clr && !fifo_empty && ((tx_state == TX_IDLE) || tx_last);
    fifo_push  = !soft_clr && (bus.ctrl_i[0] != tx_seen) && (!fifo_full || fifo_pop);
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= bus.tx_words_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      tx_seen  <= 1'b0;
    end else if (soft_clr) begin
      rd_ptr   <= wr_ptr;
      fifo_cnt <= '0;
      tx_seen  <= bus.ctrl_i[0];
    end else begin
      if (fifo_push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        tx_seen <= ~tx_seen;
      end
      if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------- TX serialiser ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_shreg <= '0;
      tx_fcnt  <= '0;
      tx_valid <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (fifo_pop) begin
            tx_shreg <= fifo_mem[rd_ptr];
            tx_fcnt  <= '0;
            tx_valid <= 1'b1;
            tx_state <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (tx_last) begin
            if (fifo_pop) begin
              // Reload straight from the FIFO so packets go out without a bubble.
              tx_shreg <= fifo_mem[rd_ptr];
              tx_fcnt  <= '0;
            end else begin
              tx_shreg <= tx_shreg >> FLIT_W;
              tx_valid <= 1'b0;
              tx_state <= TX_IDLE;
            end
          end else if (tx_hs) begin
            tx_shreg <= tx_shreg >> FLIT_W;
            tx_fcnt  <= tx_fcnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign bus.noc_tx_data_o  = tx_shreg[FLIT_W-1:0];
  assign bus.noc_tx_valid_o = tx_valid;
  assign bus.tx_state_dbg   = tx_state;

  // ---------------- RX assembler ----------------
  logic [MSG_W-1:0] rx_buf, rx_asm, rx_deliver_msg, rx_words;
  logic [FC_W-1:0]  rx_cnt;
  logic             rx_ready, rx_held, rx_held_nxt, rx_deliver;
  logic             rx_pending, rx_req, rx_ack_seen;
  logic             rx_hs, rx_done, ack_evt, pend_eff;

  always_comb begin
    rx_hs   = bus.noc_rx_valid_i && rx_ready;
    rx_done = rx_hs && (rx_cnt == FC_W'(FLITS - 1));
    ack_evt = !soft_clr && (bus.ctrl_i[1] != rx_ack_seen);
    // An ack arriving this cycle frees rx_words for a message completing this cycle.
    pend_eff = rx_pending && !ack_evt;
    rx_asm = rx_buf;
    rx_asm[int'(rx_cnt)*FLIT_W +: FLIT_W] = bus.noc_rx_data_i;
    rx_deliver     = 1'b0;
    rx_deliver_msg = rx_buf;
    rx_held_nxt    = rx_held;
    if (rx_done) begin
      if (!pend_eff && !soft_clr) begin
        rx_deliver     = 1'b1;
        rx_deliver_msg = rx_asm;
      end else begin
        rx_held_nxt = 1'b1;
      end
    end else if (rx_held && !pend_eff && !soft_clr) begin
      rx_deliver  = 1'b1;
      rx_held_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_buf      <= '0;
      rx_cnt      <= '0;
      rx_held     <= 1'b0;
      rx_ready    <= 1'b0;
      rx_pending  <= 1'b0;
      rx_req      <= 1'b0;
      rx_ack_seen <= 1'b0;
      rx_words    <= '0;
    end else begin
      if (rx_hs) begin
        rx_buf <= rx_asm;
        rx_cnt <= rx_done ? '0 : rx_cnt + 1'b1;
      end
      rx_held  <= rx_held_nxt;
      rx_ready <= !rx_held_nxt;
      if (soft_clr) begin
        rx_ack_seen <= bus.ctrl_i[1];
        rx_pending  <= 1'b0;
      end else if (ack_evt) begin
        rx_ack_seen <= ~rx_ack_seen;
        rx_pending  <= 1'b0;
      end
      if (rx_deliver) begin
        rx_words   <= rx_deliver_msg;
        rx_pending <= 1'b1;
        rx_req     <= ~rx_req;
      end
    end
  end

  assign bus.rx_words_o     = rx_words;
  assign bus.noc_rx_ready_o = rx_ready;

  // ---------------- Statistics and status ----------------
  logic [15:0] stats_q;
`ifdef HPS_NOC_MBX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || soft_clr) stats_q <= '0;
    else if (tx_last && (stats_q != 16'hFFFF)) stats_q <= stats_q + 16'd1;
  end
`else
  assign stats_q = '0;
`endif

  logic [7:0]  cnt8;
  logic [31:0] status_q;
  assign cnt8 = 8'(fifo_cnt);

  always_ff @(posedge clk) begin
    if (rst) status_q <= '0;
    else     status_q <= {stats_q, cnt8, 4'b0000, rx_pending, fifo_full, rx_req, tx_seen};
  end

  assign bus.status_o = status_q;
endmodule

// File: tb/tb_hps_noc_mailbox.sv
// Self-checking bench for hps_noc_mailbox: random messages checked against a
// message-level model (flit order, toggle handshakes, FIFO occupancy).
module tb_hps_noc_mailbox;
  localparam int NUM_WORDS  = 8;
  localparam int DATA_W     = 32;
  localparam int FLIT_W     = 64;
  localparam int FIFO_DEPTH = 4;
  localparam int MSG_W      = NUM_WORDS * DATA_W;
  localparam int FLITS      = MSG_W / FLIT_W;

  typedef logic [MSG_W-1:0] msg_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [FLIT_W-1:0] exp_q[$];
  logic [FLIT_W-1:0] got_q[$];
  int                stall_viol = 0;
  logic              prev_stall = 1'b0;
  logic [FLIT_W-1:0] prev_data = '0;
  logic              exp_rx_req = 1'b0;

  hps_noc_mailbox_if #(.NUM_WORDS(NUM_WORDS), .DATA_W(DATA_W), .FLIT_W(FLIT_W)) bus ();

  hps_noc_mailbox #(
    .NUM_WORDS(NUM_WORDS), .DATA_W(DATA_W), .FLIT_W(FLIT_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Flit monitor: sampled on the falling edge, a transfer happens on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!bus.noc_tx_valid_o || bus.noc_tx_data_o !== prev_data))
        stall_viol++;
      if (bus.noc_tx_valid_o && bus.noc_tx_ready_i) got_q.push_back(bus.noc_tx_data_o);
      prev_stall = bus.noc_tx_valid_o && !bus.noc_tx_ready_i;
      prev_data  = bus.noc_tx_data_o;
    end
  end

  // ---------------- model / driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic msg_t rand_msg();
    msg_t m;
    for (int k = 0; k < NUM_WORDS; k++) m[k*DATA_W +: DATA_W] = DATA_W'($urandom);
    return m;
  endfunction

  function automatic void push_msg(input msg_t m);
    for (int f = 0; f < FLITS; f++) exp_q.push_back(m[f*FLIT_W +: FLIT_W]);
  endfunction

  task automatic hps_tx(input msg_t m, output bit ok);
    bus.tx_words_i = m;
    bus.ctrl_i[0]  = ~bus.ctrl_i[0];
    ok = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (bus.status_o[0] == bus.ctrl_i[0]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic rx_flit(input logic [FLIT_W-1:0] d, output bit ok);
    ok = 1'b0;
    bus.noc_rx_data_i  = d;
    bus.noc_rx_valid_i = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.noc_rx_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    bus.noc_rx_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < budget) begin
      tick();
      n++;
    end
    repeat (4) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.tx_words_i = '0;
    bus.ctrl_i = '0;
    bus.noc_tx_ready_i = 1'b1;
    bus.noc_rx_data_i = '0;
    bus.noc_rx_valid_i = 1'b0;
    repeat (3) tick();
    checks++; if (bus.status_o !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 0", bus.status_o); end
    checks++; if (bus.rx_words_o !== '0) begin errors++; $display("FAIL reset_rx_words: got %h want 0", bus.rx_words_o); end
    checks++; if (bus.noc_tx_valid_o !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", bus.noc_tx_valid_o); end
    checks++; if (bus.noc_tx_data_o !== '0) begin errors++; $display("FAIL reset_tx_data: got %h want 0", bus.noc_tx_data_o); end
    checks++; if (bus.noc_rx_ready_o !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %b want 0", bus.noc_rx_ready_o); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.noc_rx_ready_o !== 1'b0) begin errors++; $display("FAIL rx_ready_early: got %b want 0", bus.noc_rx_ready_o); end
    tick();
    checks++; if (bus.noc_rx_ready_o !== 1'b1) begin errors++; $display("FAIL rx_ready_rise: got %b want 1", bus.noc_rx_ready_o); end
  endtask

  task automatic test_single_tx();
    msg_t m;
    for (int k = 0; k < NUM_WORDS; k++) m[k*DATA_W +: DATA_W] = DATA_W'(k);
    bus.noc_tx_ready_i = 1'b1;
    bus.tx_words_i = m;
    bus.ctrl_i[0] = 1'b1;
    tick();
    checks++; if (bus.status_o[0] !== 1'b0) begin errors++; $display("FAIL tx_ack_early: got %b want 0", bus.status_o[0]); end
    tick();
    checks++; if (bus.status_o[0] !== 1'b1) begin errors++; $display("FAIL tx_ack: got %b want 1", bus.status_o[0]); end
    push_msg(m);
    wait_drain(40);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL single_tx_count: got %0d flits want %0d", got_q.size(), exp_q.size()); end
    if (got_q.size() > 0) begin
      checks++; if (got_q[0] !== 64'h0000000100000000) begin errors++; $display("FAIL single_tx_flit0: got %h want 0000000100000000", got_q[0]); end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_tx_flit%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_fifo_full();
    msg_t m, pend;
    bit ok;
    int acc = 0;
    int n = 0;
    bus.noc_tx_ready_i = 1'b0;
    pend = '0;
    // One message moves into the serialiser, so DEPTH+1 requests are acked while stalled.
    for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
      m = rand_msg();
      hps_tx(m, ok);
      if (ok) begin push_msg(m); acc++; end
      else begin pend = m; break; end
    end
    checks++; if (acc != FIFO_DEPTH + 1) begin errors++; $display("FAIL full_accepts: got %0d want %0d", acc, FIFO_DEPTH + 1); end
    checks++; if (bus.status_o[15:8] !== 8'(FIFO_DEPTH)) begin errors++; $display("FAIL full_count: got %0d want %0d", bus.status_o[15:8], FIFO_DEPTH); end
    checks++; if (bus.status_o[2] !== 1'b1) begin errors++; $display("FAIL full_flag: got %b want 1", bus.status_o[2]); end
    repeat (5) tick();
    checks++; if (bus.status_o[0] === bus.ctrl_i[0]) begin errors++; $display("FAIL full_no_ack: got ack %b want %b", bus.status_o[0], ~bus.ctrl_i[0]); end
    bus.noc_tx_ready_i = 1'b1;
    while (bus.status_o[0] !== bus.ctrl_i[0] && n < 30) begin tick(); n++; end
    checks++; if (bus.status_o[0] !== bus.ctrl_i[0]) begin errors++; $display("FAIL full_late_ack: got %b want %b", bus.status_o[0], bus.ctrl_i[0]); end
    push_msg(pend);
    wait_drain(100);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL full_flit_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_flit%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (bus.status_o[15:8] !== 8'd0 || bus.status_o[2] !== 1'b0) begin errors++; $display("FAIL full_drained: count %0d full %b want 0 0", bus.status_o[15:8], bus.status_o[2]); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_stall();
    msg_t m;
    bit ok;
    int n = 0;
    bus.noc_tx_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m = rand_msg();
      hps_tx(m, ok);
      checks++; if (!ok) begin errors++; $display("FAIL stall_ack%0d: got no ack want ack", i); end
      push_msg(m);
    end
    stall_viol = 0;
    bus.noc_tx_ready_i = 1'($urandom_range(0, 1));
    while (got_q.size() < exp_q.size() && n < 200) begin
      tick();
      bus.noc_tx_ready_i = ~bus.noc_tx_ready_i;
      n++;
    end
    bus.noc_tx_ready_i = 1'b1;
    repeat (4) tick();
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_hold: got %0d changes while stalled want 0", stall_viol); end
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_flit_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_flit%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    msg_t m;
    bit ok;
    int highs = 0;
    bus.noc_tx_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m = rand_msg();
      hps_tx(m, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_ack%0d: got no ack want ack", i); end
      push_msg(m);
    end
    bus.noc_tx_ready_i = 1'b1;
    for (int i = 0; i < 2 * FLITS; i++) begin
      @(negedge clk);
      if (bus.noc_tx_valid_o) highs++;
    end
    tick();
    checks++; if (highs != 2 * FLITS) begin errors++; $display("FAIL b2b_no_bubble: got %0d valid cycles want %0d", highs, 2 * FLITS); end
    wait_drain(40);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_flit_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_flit%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_rx();
    msg_t m1, m2;
    bit ok;
    logic [FLIT_W-1:0] f;
    for (int i = 0; i < FLITS; i++) begin
      f = {(FLIT_W/16){16'hAAAA}};
      m1[i*FLIT_W +: FLIT_W] = f;
      rx_flit(f, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rx1_flit%0d_accept: got not ready want ready", i); end
    end
    exp_rx_req = ~exp_rx_req;
    checks++; if (bus.rx_words_o !== m1) begin errors++; $display("FAIL rx1_words: got %h want %h", bus.rx_words_o, m1); end
    checks++; if (bus.noc_rx_ready_o !== 1'b1) begin errors++; $display("FAIL rx1_ready: got %b want 1", bus.noc_rx_ready_o); end
    tick();
    checks++; if (bus.status_o[1] !== exp_rx_req || bus.status_o[3] !== 1'b1) begin errors++; $display("FAIL rx1_status: req %b pend %b want %b 1", bus.status_o[1], bus.status_o[3], exp_rx_req); end
    for (int i = 0; i < FLITS; i++) begin
      f = {$urandom, $urandom};
      m2[i*FLIT_W +: FLIT_W] = f;
      rx_flit(f, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rx2_flit%0d_accept: got not ready want ready", i); end
    end
    checks++; if (bus.noc_rx_ready_o !== 1'b0) begin errors++; $display("FAIL rx2_backpressure: got %b want 0", bus.noc_rx_ready_o); end
    repeat (3) tick();
    checks++; if (bus.noc_rx_ready_o !== 1'b0 || bus.rx_words_o !== m1) begin errors++; $display("FAIL rx2_hold: ready %b words %h want 0 %h", bus.noc_rx_ready_o, bus.rx_words_o, m1); end
    bus.ctrl_i[1] = ~bus.ctrl_i[1];
    exp_rx_req = ~exp_rx_req;
    tick();
    checks++; if (bus.rx_words_o !== m2) begin errors++; $display("FAIL rx2_words: got %h want %h", bus.rx_words_o, m2); end
    checks++; if (bus.noc_rx_ready_o !== 1'b1) begin errors++; $display("FAIL rx2_ready: got %b want 1", bus.noc_rx_ready_o); end
    tick();
    checks++; if (bus.status_o[1] !== exp_rx_req || bus.status_o[3] !== 1'b1) begin errors++; $display("FAIL rx2_status: req %b pend %b want %b 1", bus.status_o[1], bus.status_o[3], exp_rx_req); end
    bus.ctrl_i[1] = ~bus.ctrl_i[1];
    tick(); tick();
    checks++; if (bus.status_o[3] !== 1'b0) begin errors++; $display("FAIL rx_ack_clears: got %b want 0", bus.status_o[3]); end
  endtask

  task automatic test_soft_clear();
    msg_t m;
    bit ok;
    for (int i = 0; i < FLITS; i++) begin
      rx_flit({$urandom, $urandom}, ok);
      checks++; if (!ok) begin errors++; $display("FAIL clr_rx_flit%0d: got not ready want ready", i); end
    end
    exp_rx_req = ~exp_rx_req;
    tick();
    checks++; if (bus.status_o[3] !== 1'b1) begin errors++; $display("FAIL clr_rx_pending_set: got %b want 1", bus.status_o[3]); end
    bus.noc_tx_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m = rand_msg();
      hps_tx(m, ok);
      checks++; if (!ok) begin errors++; $display("FAIL clr_ack%0d: got no ack want ack", i); end
      if (i == 0) push_msg(m);
    end
    checks++; if (bus.status_o[15:8] !== 8'd3) begin errors++; $display("FAIL clr_queued: got %0d want 3", bus.status_o[15:8]); end
    bus.ctrl_i[2] = 1'b1;
    tick();
    bus.ctrl_i[0] = ~bus.ctrl_i[0];
    tick();
    bus.noc_tx_ready_i = 1'b1;
    repeat (FLITS + 2) tick();
    bus.ctrl_i[2] = 1'b0;
    repeat (20) tick();
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL clr_flit_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL clr_flit%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (bus.status_o[15:8] !== 8'd0) begin errors++; $display("FAIL clr_count: got %0d want 0", bus.status_o[15:8]); end
    checks++; if (bus.noc_tx_valid_o !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b want 0", bus.noc_tx_valid_o); end
    checks++; if (bus.status_o[0] !== bus.ctrl_i[0]) begin errors++; $display("FAIL clr_tx_seen: got %b want %b", bus.status_o[0], bus.ctrl_i[0]); end
    checks++; if (bus.status_o[3] !== 1'b0 || bus.status_o[1] !== exp_rx_req) begin errors++; $display("FAIL clr_rx_status: pend %b req %b want 0 %b", bus.status_o[3], bus.status_o[1], exp_rx_req); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_stats();
    msg_t m;
    bit ok;
    logic [15:0] exp_stats;
    bus.noc_tx_ready_i = 1'b1;
    bus.ctrl_i[2] = 1'b1;
    tick();
    bus.ctrl_i[2] = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      m = rand_msg();
      hps_tx(m, ok);
      checks++; if (!ok) begin errors++; $display("FAIL stats_ack%0d: got no ack want ack", i); end
      push_msg(m);
    end
    wait_drain(60);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stats_flit_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    got_q.delete(); exp_q.delete();
`ifdef HPS_NOC_MBX_STATS_EN
    exp_stats = 16'd3;
`else
    exp_stats = 16'd0;
`endif
    checks++; if (bus.status_o[31:16] !== exp_stats) begin errors++; $display("FAIL stats_count: got %0d want %0d", bus.status_o[31:16], exp_stats); end
    bus.ctrl_i[2] = 1'b1;
    tick();
    bus.ctrl_i[2] = 1'b0;
    tick(); tick();
    checks++; if (bus.status_o[31:16] !== 16'd0) begin errors++; $display("FAIL stats_clear: got %0d want 0", bus.status_o[31:16]); end
  endtask

  initial begin
    test_reset();
    test_single_tx();
    test_fifo_full();
    test_stall();
    test_back_to_back();
    test_rx();
    test_soft_clear();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
